sudoku_solve_ctrl: RTL and testbench
====================================

Name: sudoku_solve_ctrl

Overview:
- Iterative constraint-propagation sequencer for the combinational sudoku deduction engine.
- Latches a 729-bit candidate mask and repeatedly presents it to the engine.
- Merges each forced-digit result back into the mask.
- Stops on solved, conflict or no-progress, and reports status through a start/done handshake.

Parameters:
- ENG_LAT, 1: cycles from eng_mask stable to eng_ans valid. Range 1..15. The engine output is sampled after ENG_LAT cycles in WAIT.
- MAX_ITER, 64: iteration cap. Used only when SUDOKU_CTRL_TIMEOUT_EN is defined.
- ITER_W, 10: width of iter_count. Must hold 729.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; accepted only in IDLE or DONE
- mask_in  input  729  initial candidate mask; sampled on an accepted start
- eng_mask  output  729  mask driven to the engine; equals the internal mask register
- eng_ans  input  729  engine forced-digit result
- mask_out  output  729  current mask register, valid when done=1
- busy  output  1  high from the cycle after an accepted start until done rises
- done  output  1  held high in DONE until the next accepted start
- solved  output  1  valid with done
- conflict  output  1  valid with done
- stalled  output  1  valid with done; also set on timeout
- iter_count  output  ITER_W  completed UPDATE cycles

Behaviour:
- Bit mapping: bit r*81+c*9+d means digit d+1 is a candidate at row r, column c.
- Cell k is the 9-bit slice [k*9+8:k*9].
- Reset (async, rst_n=0):
  - state=IDLE; mask=0; iter_count=0.
  - busy, done, solved, conflict and stalled all 0.
  - Applies immediately, including mid-solve; no completion is reported.
- IDLE / DONE, start=1:
  - mask<=mask_in; iter_count<=0; clear done and all flags.
  - Next state is CHECK. busy=1 from the next cycle.
- CHECK (1 cycle), evaluates the current mask. Priority is conflict > solved.
  - Any cell==0 -> conflict=1, go to DONE.
  - Every cell has exactly one bit set -> solved=1, go to DONE.
  - Otherwise go to WAIT with the wait counter=0.
- WAIT: count ENG_LAT cycles, then go to UPDATE. The mask is held constant throughout WAIT.
- UPDATE (1 cycle), computed per cell:
  - a = eng_ans cell; m = mask cell.
  - If a has more than one bit set -> conflict.
  - If a is nonzero and (a & m)==0 -> conflict.
  - If a has one bit set -> next cell = a & m.
  - If a==0 -> next cell = m.
  - Any conflict: set conflict=1, leave the mask unchanged, go to DONE.
  - Else if next mask == mask: set stalled=1, go to DONE.
  - Else: mask<=next, iter_count+=1, go to CHECK.
- The mask only ever loses bits, so the loop terminates within 729 iterations.
- Entering DONE: done=1 and busy=0 in the same cycle.
- Exactly one of solved, conflict, stalled is 1 while done=1.
- start while busy is ignored.
- start on the same cycle done rises is ignored. A start is accepted only when it is sampled while the state is already IDLE or DONE.
- Latency, solvable with 0 iterations: start -> done is 2 cycles (CHECK, DONE).
- Each iteration costs ENG_LAT+2 cycles.
- iter_count saturates at 2^ITER_W-1.

Optional Feature:
- Macro: SUDOKU_CTRL_TIMEOUT_EN.
- Defined: in UPDATE, a successful mask change that makes iter_count equal MAX_ITER goes to DONE with stalled=1, instead of CHECK. The mask is still updated.
- Undefined: no cap; MAX_ITER is ignored; termination relies on monotonic mask shrinkage only.

Test Plan:
- Reset mid-solve:
  - Stimulus: assert rst_n=0 in WAIT.
  - Response: all outputs 0 asynchronously; after release a new start solves normally.
- Already-solved grid (one-hot in every cell):
  - Stimulus: start, eng_ans=0.
  - Response: done 2 cycles after start; solved=1; iter_count=0; mask_out==mask_in.
- Two-step propagation, ENG_LAT=1:
  - Stimulus: mask_in with cell 0 = 9'h003 and all other cells one-hot. Engine model returns a=9'h001 for cell 0, and 0 for all other cells.
  - Response: one UPDATE; cell 0 becomes 9'h001; solved=1; iter_count=1; done at cycle 5.
- Conflict:
  - Stimulus: cell 40 of mask_in = 0.
  - Response: conflict=1 after CHECK; iter_count=0.
  - Stimulus: separately, eng_ans cell 3 = 9'h006.
  - Response: conflict=1; mask unchanged.
- Stall:
  - Stimulus: cells with multiple candidates, eng_ans all 0.
  - Response: stalled=1; iter_count=0; mask_out==mask_in.
- Handshake / timeout:
  - Stimulus: start pulses while busy.
  - Response: ignored.
  - Stimulus: with SUDOKU_CTRL_TIMEOUT_EN and MAX_ITER=2, an engine model clearing one bit per iteration.
  - Response: done with stalled=1; iter_count=2.

Source files
------------

// File: rtl/sudoku_solve_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sudoku_solve_ctrl                                            |
// | Description : Iterative constraint-propagation sequencer. Latches a        |
// |               729-bit candidate mask, presents it to a combinational       |
// |               deduction engine and merges forced digits back until the     |
// |               grid is solved, conflicts, or stops making progress.         |
// |               Optional iteration cap: define SUDOKU_CTRL_TIMEOUT_EN.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sudoku_solve_ctrl #(
  parameter int ENG_LAT  = 1,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [728:0]      mask_in,
  output logic [728:0]      eng_mask,
  input  logic [728:0]      eng_ans,
  output logic [728:0]      mask_out,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic              conflict,
  output logic              stalled,
  output logic [ITER_W-1:0] iter_count
);

  localparam int         C_CELLS     = 81;
  localparam logic [3:0] C_WAIT_LAST = 4'(ENG_LAT - 1);

`ifdef SUDOKU_CTRL_TIMEOUT_EN
  localparam logic C_CAP_EN = 1'b1;
`else
  localparam logic C_CAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [728:0]      r_mask, w_mask_nxt;
  logic [ITER_W-1:0] r_iter, w_iter_nxt;
  logic [3:0]        r_wait, w_wait_nxt;
  logic              r_solved, w_solved_nxt;
  logic              r_conflict, w_conflict_nxt;
  logic              r_stalled, w_stalled_nxt;

  logic [C_CELLS-1:0] w_cell_zero;
  logic [C_CELLS-1:0] w_cell_onehot;
  logic [C_CELLS-1:0] w_cell_conf;
  logic [728:0]       w_merged;
  logic [ITER_W-1:0]  w_iter_inc;
  logic               w_cap_hit;

  // Per-cell evaluation of the current mask and of the engine answer
  for (genvar k = 0; k < C_CELLS; k++) begin : g_cell
    logic [8:0] w_m;
    logic [8:0] w_a;
    logic       w_a_multi;
    assign w_m              = r_mask[k*9 +: 9];
    assign w_a              = eng_ans[k*9 +: 9];
    assign w_a_multi        = ((w_a & (w_a - 9'd1)) != 9'd0);
    assign w_cell_zero[k]   = (w_m == 9'd0);
    assign w_cell_onehot[k] = (w_m != 9'd0) && ((w_m & (w_m - 9'd1)) == 9'd0);
    assign w_cell_conf[k]   = (w_a != 9'd0) && (w_a_multi || ((w_a & w_m) == 9'd0));
    // A multi-bit answer is a conflict, so the merged value is only used
    // when the answer is zero or a single forced digit.
    assign w_merged[k*9 +: 9] = (w_a == 9'd0) ? w_m : (w_a & w_m);
  end

  assign w_iter_inc = (r_iter == {ITER_W{1'b1}}) ? r_iter : (r_iter + 1'b1);
  assign w_cap_hit  = (w_iter_inc == ITER_W'(MAX_ITER));

  // State, mask, counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_iter     <= '0;
      r_wait     <= '0;
      r_solved   <= 1'b0;
      r_conflict <= 1'b0;
      r_stalled  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_iter     <= w_iter_nxt;
      r_wait     <= w_wait_nxt;
      r_solved   <= w_solved_nxt;
      r_conflict <= w_conflict_nxt;
      r_stalled  <= w_stalled_nxt;
    end
  end

  // Next-state and next-value decode for the propagation loop
  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_iter_nxt     = r_iter;
    w_wait_nxt     = r_wait;
    w_solved_nxt   = r_solved;
    w_conflict_nxt = r_conflict;
    w_stalled_nxt  = r_stalled;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_mask_nxt     = mask_in;
          w_iter_nxt     = '0;
          w_solved_nxt   = 1'b0;
          w_conflict_nxt = 1'b0;
          w_stalled_nxt  = 1'b0;
          w_state_nxt    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (|w_cell_zero) begin
          w_conflict_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end else if (&w_cell_onehot) begin
          w_solved_nxt = 1'b1;
          w_state_nxt  = S_DONE;
        end else begin
          w_wait_nxt  = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait == C_WAIT_LAST) begin
          w_state_nxt = S_UPDATE;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      S_UPDATE: begin
        if (|w_cell_conf) begin
          w_conflict_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end else if (w_merged == r_mask) begin
          w_stalled_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_mask_nxt = w_merged;
          w_iter_nxt = w_iter_inc;
          // With the cap enabled the mask is still committed before stopping
          if (C_CAP_EN && w_cap_hit) begin
            w_stalled_nxt = 1'b1;
            w_state_nxt   = S_DONE;
          end else begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign eng_mask   = r_mask;
  assign mask_out   = r_mask;
  assign busy       = (r_state == S_CHECK) || (r_state == S_WAIT) || (r_state == S_UPDATE);
  assign done       = (r_state == S_DONE);
  assign solved     = r_solved;
  assign conflict   = r_conflict;
  assign stalled    = r_stalled;
  assign iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_solve_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sudoku_solve_ctrl                                         |
// | Description : Directed self-checking bench for sudoku_solve_ctrl with a    |
// |               behavioural engine model selected per scenario.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sudoku_solve_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [728:0] mask_in;
  logic [728:0] eng_mask;
  logic [728:0] eng_ans;
  logic [728:0] mask_out;
  logic         busy;
  logic         done;
  logic         solved;
  logic         conflict;
  logic         stalled;
  logic [9:0]   iter_count;

  int checks   = 0;
  int failures = 0;
  int eng_mode = 0;

  sudoku_solve_ctrl #(
    .ENG_LAT (1),
    .MAX_ITER(2),
    .ITER_W  (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mask_in   (mask_in),
    .eng_mask  (eng_mask),
    .eng_ans   (eng_ans),
    .mask_out  (mask_out),
    .busy      (busy),
    .done      (done),
    .solved    (solved),
    .conflict  (conflict),
    .stalled   (stalled),
    .iter_count(iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: 0 none, 1 force digit 1 in cell 0, 2 illegal two-bit
  // answer in cell 3, 3 resolve the first multi-candidate cell to its lowest digit
  function automatic logic [728:0] eng_model(input int mode, input logic [728:0] m);
    logic [728:0] a;
    logic [8:0]   c;
    bit           found;
    a     = '0;
    found = 1'b0;
    case (mode)
      1: a[8:0] = 9'h001;
      2: a[27 +: 9] = 9'h006;
      3: begin
        for (int k = 0; k < 81; k++) begin
          c = m[k*9 +: 9];
          if (!found && ((c & (c - 9'd1)) != 9'd0)) begin
            a[k*9 +: 9] = c & (~c + 9'd1);
            found = 1'b1;
          end
        end
      end
      default: a = '0;
    endcase
    return a;
  endfunction

  // Combinational engine driven from the controller's presented mask
  always_comb eng_ans = eng_model(eng_mode, eng_mask);

  function automatic logic [728:0] solved_grid();
    logic [728:0] g;
    g = '0;
    for (int k = 0; k < 81; k++) g[k*9 + (k % 9)] = 1'b1;
    return g;
  endfunction

  function automatic logic [728:0] set_cell(input logic [728:0] g, input int k,
                                            input logic [8:0] v);
    logic [728:0] r;
    r = g;
    r[k*9 +: 9] = v;
    return r;
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one sampled edge; returns one cycle after that edge
  task automatic do_start(input logic [728:0] m);
    mask_in = m;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  logic [728:0] g_solved;
  logic [728:0] m;
  logic [728:0] exp_mask;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mask_in  = '0;
    g_solved = solved_grid();

    // Reset state
    #12;
    chk("rst_busy", 729'(busy), 729'(0));
    chk("rst_done", 729'(done), 729'(0));
    chk("rst_flags", 729'({solved, conflict, stalled}), 729'(0));
    chk("rst_iter", 729'(iter_count), 729'(0));
    chk("rst_mask", mask_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Already-solved grid: done two cycles after start
    eng_mode = 0;
    do_start(g_solved);
    chk("solved0_busy_c1", 729'({busy, done}), 729'(2'b10));
    tick();
    chk("solved0_done_c2", 729'({busy, done}), 729'(2'b01));
    chk("solved0_flags", 729'({solved, conflict, stalled}), 729'(3'b100));
    chk("solved0_iter", 729'(iter_count), 729'(0));
    chk("solved0_mask", mask_out, g_solved);

    // One propagation step; start pulses while busy and on the done edge are ignored
    eng_mode = 1;
    m = set_cell(g_solved, 0, 9'h003);
    do_start(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    start = 1'b1;
    chk("step_busy_c4", 729'({busy, done}), 729'(2'b10));
    tick();
    start = 1'b0;
    chk("step_done_c5", 729'({busy, done}), 729'(2'b01));
    chk("step_flags", 729'({solved, conflict, stalled}), 729'(3'b100));
    chk("step_iter", 729'(iter_count), 729'(1));
    chk("step_cell0", 729'(mask_out[8:0]), 729'(9'h001));
    chk("step_mask", mask_out, g_solved);
    tick();
    chk("step_done_held", 729'({busy, done, iter_count}), 729'({2'b01, 10'd1}));

    // Empty cell: conflict straight out of CHECK
    eng_mode = 0;
    m = set_cell(g_solved, 40, 9'h000);
    do_start(m);
    tick();
    chk("zero_done", 729'(done), 729'(1));
    chk("zero_flags", 729'({solved, conflict, stalled}), 729'(3'b010));
    chk("zero_iter", 729'(iter_count), 729'(0));

    // Multi-bit engine answer: conflict, mask untouched
    eng_mode = 2;
    m = set_cell(g_solved, 3, 9'h1FF);
    do_start(m);
    tick(2);
    chk("ansconf_c3", 729'(done), 729'(0));
    tick();
    chk("ansconf_flags", 729'({done, solved, conflict, stalled}), 729'(4'b1010));
    chk("ansconf_mask", mask_out, m);
    chk("ansconf_iter", 729'(iter_count), 729'(0));

    // No progress: stalled
    eng_mode = 0;
    m = set_cell(set_cell(set_cell(g_solved, 0, 9'h1FF), 1, 9'h1FF), 2, 9'h1FF);
    do_start(m);
    tick(3);
    chk("stall_flags", 729'({done, solved, conflict, stalled}), 729'(4'b1001));
    chk("stall_iter", 729'(iter_count), 729'(0));
    chk("stall_mask", mask_out, m);

    // Three cells resolved one per iteration
    eng_mode = 3;
    m = set_cell(set_cell(set_cell(g_solved, 0, 9'h003), 1, 9'h003), 2, 9'h003);
`ifdef SUDOKU_CTRL_TIMEOUT_EN
    exp_mask = set_cell(set_cell(m, 0, 9'h001), 1, 9'h001);
    do_start(m);
    tick(5);
    chk("cap_c6", 729'(done), 729'(0));
    tick();
    chk("cap_flags", 729'({done, solved, conflict, stalled}), 729'(4'b1001));
    chk("cap_iter", 729'(iter_count), 729'(2));
    chk("cap_mask", mask_out, exp_mask);
`else
    exp_mask = set_cell(set_cell(set_cell(m, 0, 9'h001), 1, 9'h001), 2, 9'h001);
    do_start(m);
    tick(9);
    chk("multi_c10", 729'(done), 729'(0));
    tick();
    chk("multi_flags", 729'({done, solved, conflict, stalled}), 729'(4'b1100));
    chk("multi_iter", 729'(iter_count), 729'(3));
    chk("multi_mask", mask_out, exp_mask);
`endif

    // Asynchronous reset while in WAIT, then a normal solve
    eng_mode = 0;
    m = set_cell(g_solved, 5, 9'h0F0);
    do_start(m);
    tick();
    chk("mid_busy", 729'(busy), 729'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 729'({busy, done, solved, conflict, stalled}), 729'(0));
    chk("mid_rst_iter", 729'(iter_count), 729'(0));
    chk("mid_rst_mask", mask_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 729'({busy, done}), 729'(0));
    do_start(g_solved);
    tick();
    chk("post_rst_flags", 729'({done, solved, conflict, stalled}), 729'(4'b1100));
    chk("post_rst_mask", mask_out, g_solved);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
